mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Pipeline register between the memory stage and the write-back stage.
//   Non-load instructions are forwarded with one cycle of latency. Loads whose
//   data is already valid are formatted and forwarded in the same way. Loads
//   whose data has not yet arrived park their control fields in internal
//   latches. The stage then raises busy_o until dmem_rvalid_i arrives, and
//   then emits the completed load.
//
// Ports
//   clk             core clock, rising edge
//   rstn            synchronous reset, active HIGH despite the name
//   stall_i         hold all output registers (RUN only)
//   flush_i         insert a bubble (RUN only, beats stall_i)
//   valid_i         mem stage presents a valid instruction
//   inst_i          instruction word
//   instaddr_i      instruction address
//   regs_wen_i      instruction writes rd
//   rd_addr_i       destination register index
//   rd_data_i       ALU/CSR result for non-load instructions
//   is_load_i       instruction is a load
//   load_funct3_i   load type (LB/LH/LW/LBU/LHU)
//   load_off_i      load address bits [1:0]
//   dmem_rdata_i    data memory read word
//   dmem_rvalid_i   dmem_rdata_i valid this cycle
//   busy_o          waiting for load data (combinational from state)
//   valid_o .. rd_data_o   registered write-back stage inputs
// -----------------------------------------------------------------------------
module mem_wb_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] instaddr_i,
    input  logic        regs_wen_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        is_load_i,
    input  logic [2:0]  load_funct3_i,
    input  logic [1:0]  load_off_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_rvalid_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] instaddr_o,
    output logic        regs_wen_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o
);

    // Canonical NOP (addi x0, x0, 0) shown in bubbles.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Source selection for the output registers in the coming cycle.
    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_BUBBLE = 3'd1,
        SEL_ALU    = 3'd2,
        SEL_LOAD   = 3'd3,
        SEL_PEND   = 3'd4
    } sel_t;

    // Format a load word. Bit 32 flags a defined funct3. An undefined funct3
    // yields zero data and suppresses the register write.
    function automatic logic [32:0] load_format(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [32:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        // Misaligned halfwords ignore off[0].
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {1'b1, {24{b[7]}}, b};
            3'b001:  r = {1'b1, {16{h[15]}}, h};
            3'b010:  r = {1'b1, word};
            3'b100:  r = {1'b1, 24'd0, b};
            3'b101:  r = {1'b1, 16'd0, h};
            default: r = 33'd0;
        endcase
        return r;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    sel_t        w_sel;

    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_instaddr;
    logic        r_wen;
    logic [4:0]  r_rd;
    logic [31:0] r_data;

    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_instaddr;
    logic        w_wen;
    logic [4:0]  w_rd;
    logic [31:0] w_data;

    // Fields of a load that is waiting for its data.
    logic [31:0] r_pend_inst;
    logic [31:0] r_pend_addr;
    logic        r_pend_wen;
    logic [4:0]  r_pend_rd;
    logic [2:0]  r_pend_f3;
    logic [1:0]  r_pend_off;
    logic        w_pend_latch;

    logic [32:0] w_fmt_run;
    logic [32:0] w_fmt_pend;

    // Next-state and output source selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel        = SEL_HOLD;
        w_pend_latch = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (flush_i) begin
                    w_sel = SEL_BUBBLE;
                end else if (stall_i) begin
                    w_sel = SEL_HOLD;
                end else if (!valid_i) begin
                    w_sel = SEL_BUBBLE;
                end else if (!is_load_i) begin
                    w_sel = SEL_ALU;
                end else if (dmem_rvalid_i) begin
                    w_sel = SEL_LOAD;
                end else begin
                    // Load data not yet returned: park the load and stall upstream.
                    w_sel        = SEL_BUBBLE;
                    w_pend_latch = 1'b1;
                    w_state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The load is committed, so flush/stall/valid play no role here.
                if (dmem_rvalid_i) begin
                    w_sel       = SEL_PEND;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_sel = SEL_BUBBLE;
                end
            end
            default: begin
                w_sel       = SEL_BUBBLE;
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Output register next values from the chosen source.
    always_comb begin
        w_fmt_run  = load_format(load_funct3_i, load_off_i, dmem_rdata_i);
        w_fmt_pend = load_format(r_pend_f3, r_pend_off, dmem_rdata_i);
        w_valid    = r_valid;
        w_inst     = r_inst;
        w_instaddr = r_instaddr;
        w_wen      = r_wen;
        w_rd       = r_rd;
        w_data     = r_data;
        case (w_sel)
            SEL_HOLD: begin
                w_valid = r_valid;
            end
            SEL_BUBBLE: begin
                w_valid    = 1'b0;
                w_inst     = NOP_INST;
                w_instaddr = 32'd0;
                w_wen      = 1'b0;
                w_rd       = 5'd0;
                w_data     = 32'd0;
            end
            SEL_ALU: begin
                w_valid    = 1'b1;
                w_inst     = inst_i;
                w_instaddr = instaddr_i;
                w_wen      = regs_wen_i & (rd_addr_i != 5'd0);
                w_rd       = rd_addr_i;
                w_data     = rd_data_i;
            end
            SEL_LOAD: begin
                w_valid    = 1'b1;
                w_inst     = inst_i;
                w_instaddr = instaddr_i;
                w_wen      = regs_wen_i & (rd_addr_i != 5'd0) & w_fmt_run[32];
                w_rd       = rd_addr_i;
                w_data     = w_fmt_run[31:0];
            end
            SEL_PEND: begin
                w_valid    = 1'b1;
                w_inst     = r_pend_inst;
                w_instaddr = r_pend_addr;
                w_wen      = r_pend_wen & (r_pend_rd != 5'd0) & w_fmt_pend[32];
                w_rd       = r_pend_rd;
                w_data     = w_fmt_pend[31:0];
            end
            default: begin
                w_valid    = 1'b0;
                w_inst     = NOP_INST;
                w_instaddr = 32'd0;
                w_wen      = 1'b0;
                w_rd       = 5'd0;
                w_data     = 32'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write-back output registers.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_valid    <= 1'b0;
            r_inst     <= NOP_INST;
            r_instaddr <= 32'd0;
            r_wen      <= 1'b0;
            r_rd       <= 5'd0;
            r_data     <= 32'd0;
        end else begin
            r_valid    <= w_valid;
            r_inst     <= w_inst;
            r_instaddr <= w_instaddr;
            r_wen      <= w_wen;
            r_rd       <= w_rd;
            r_data     <= w_data;
        end
    end

    // Latches for a load that is waiting on memory.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_pend_inst <= 32'd0;
            r_pend_addr <= 32'd0;
            r_pend_wen  <= 1'b0;
            r_pend_rd   <= 5'd0;
            r_pend_f3   <= 3'd0;
            r_pend_off  <= 2'd0;
        end else if (w_pend_latch) begin
            r_pend_inst <= inst_i;
            r_pend_addr <= instaddr_i;
            r_pend_wen  <= regs_wen_i;
            r_pend_rd   <= rd_addr_i;
            r_pend_f3   <= load_funct3_i;
            r_pend_off  <= load_off_i;
        end else begin
            r_pend_inst <= r_pend_inst;
            r_pend_addr <= r_pend_addr;
            r_pend_wen  <= r_pend_wen;
            r_pend_rd   <= r_pend_rd;
            r_pend_f3   <= r_pend_f3;
            r_pend_off  <= r_pend_off;
        end
    end

    assign busy_o     = (r_state == ST_WAIT);
    assign valid_o    = r_valid;
    assign inst_o     = r_inst;
    assign instaddr_o = r_instaddr;
    assign regs_wen_o = r_wen;
    assign rd_addr_o  = r_rd;
    assign rd_data_o  = r_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rstn, stall_i, flush_i, valid_i, regs_wen_i, is_load_i, dmem_rvalid_i;
    logic [31:0] inst_i, instaddr_i, rd_data_i, dmem_rdata_i;
    logic [4:0]  rd_addr_i;
    logic [2:0]  load_funct3_i;
    logic [1:0]  load_off_i;
    logic        busy_o, valid_o, regs_wen_o;
    logic [31:0] inst_o, instaddr_o, rd_data_o;
    logic [4:0]  rd_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rstn(rstn), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .inst_i(inst_i), .instaddr_i(instaddr_i),
        .regs_wen_i(regs_wen_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
        .is_load_i(is_load_i), .load_funct3_i(load_funct3_i), .load_off_i(load_off_i),
        .dmem_rdata_i(dmem_rdata_i), .dmem_rvalid_i(dmem_rvalid_i),
        .busy_o(busy_o), .valid_o(valid_o), .inst_o(inst_o), .instaddr_o(instaddr_o),
        .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
    );

    // ---------------- reference model ----------------
    bit          m_wait;
    logic [31:0] p_inst, p_addr;
    bit          p_wen;
    int          p_rd, p_f3, p_off;
    bit          m_valid, m_wen, m_busy;
    logic [31:0] m_inst, m_addr, m_data;
    int          m_rd;

    // Returns 1 if funct3 is a defined load; value via output.
    function automatic bit ref_load(input int f3, input int off, input logic [31:0] w,
                                    output logic [31:0] val);
        longint b, h;
        b = (longint'(w) >> (8 * off)) & 64'hFF;
        h = (longint'(w) >> ((off >= 2) ? 16 : 0)) & 64'hFFFF;
        case (f3)
            0: begin if (b > 127) b = b - 256; val = 32'(b); return 1'b1; end
            1: begin if (h > 32767) h = h - 65536; val = 32'(h); return 1'b1; end
            2: begin val = w; return 1'b1; end
            4: begin val = 32'(b); return 1'b1; end
            5: begin val = 32'(h); return 1'b1; end
            default: begin val = 32'd0; return 1'b0; end
        endcase
    endfunction

    task automatic m_put(input bit v, input logic [31:0] ins, input logic [31:0] a,
                         input bit wen, input int rd, input logic [31:0] d);
        m_valid = v; m_inst = ins; m_addr = a; m_rd = rd; m_data = d;
        m_wen = wen && v && (rd != 0);
    endtask

    task automatic m_bubble();
        m_put(1'b0, 32'h13, 32'd0, 1'b0, 0, 32'd0);
    endtask

    task automatic model_step();
        logic [31:0] v;
        bit ok;
        if (rstn) begin
            m_wait = 1'b0; m_bubble();
        end else if (m_wait) begin
            if (dmem_rvalid_i) begin
                ok = ref_load(p_f3, p_off, dmem_rdata_i, v);
                m_put(1'b1, p_inst, p_addr, p_wen && ok, p_rd, v);
                m_wait = 1'b0;
            end else m_bubble();
        end else if (flush_i) m_bubble();
        else if (stall_i) begin end
        else if (!valid_i) m_bubble();
        else if (!is_load_i)
            m_put(1'b1, inst_i, instaddr_i, regs_wen_i, int'(rd_addr_i), rd_data_i);
        else if (dmem_rvalid_i) begin
            ok = ref_load(int'(load_funct3_i), int'(load_off_i), dmem_rdata_i, v);
            m_put(1'b1, inst_i, instaddr_i, regs_wen_i && ok, int'(rd_addr_i), v);
        end else begin
            m_wait = 1'b1;
            p_inst = inst_i; p_addr = instaddr_i; p_wen = regs_wen_i;
            p_rd = int'(rd_addr_i); p_f3 = int'(load_funct3_i); p_off = int'(load_off_i);
            m_bubble();
        end
        m_busy = m_wait;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance model with current inputs, clock, compare against model.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(valid_o),    32'(m_valid));
        chk({tag, ".inst"},  inst_o,          m_inst);
        chk({tag, ".addr"},  instaddr_o,      m_addr);
        chk({tag, ".wen"},   32'(regs_wen_o), 32'(m_wen));
        chk({tag, ".rd"},    32'(rd_addr_o),  32'(m_rd));
        chk({tag, ".data"},  rd_data_o,       m_data);
        chk({tag, ".busy"},  32'(busy_o),     32'(m_busy));
    endtask

    task automatic expect_out(input string tag, input bit v, input logic [31:0] ins,
                              input logic [31:0] a, input bit wen, input logic [4:0] rd,
                              input logic [31:0] d, input bit busy);
        chk({tag, ".x_valid"}, 32'(valid_o),    32'(v));
        chk({tag, ".x_inst"},  inst_o,          ins);
        chk({tag, ".x_addr"},  instaddr_o,      a);
        chk({tag, ".x_wen"},   32'(regs_wen_o), 32'(wen));
        chk({tag, ".x_rd"},    32'(rd_addr_o),  32'(rd));
        chk({tag, ".x_data"},  rd_data_o,       d);
        chk({tag, ".x_busy"},  32'(busy_o),     32'(busy));
    endtask

    task automatic idle_inputs();
        rstn = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        inst_i = 32'd0; instaddr_i = 32'd0; regs_wen_i = 1'b0; rd_addr_i = 5'd0;
        rd_data_i = 32'd0; is_load_i = 1'b0; load_funct3_i = 3'd0; load_off_i = 2'd0;
        dmem_rdata_i = 32'd0; dmem_rvalid_i = 1'b0;
    endtask

    typedef struct {
        logic        stall, flush, valid, wen, is_load, rvalid;
        logic [31:0] inst, addr, rdata_alu, dmem;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic        e_valid, e_wen;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[8];

    initial begin
        idle_inputs();
        m_wait = 1'b0;
        m_bubble();
        m_busy = 1'b0;

        //         stall flush valid wen load rv inst          addr     alu      dmem          rd  f3    off   ev  ew  erd  edata
        vt[0] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h006282B3,32'h100,32'h1234,32'h0,       5'd5,3'd0,2'd0,1'b1,1'b1,5'd5,32'h00001234};
        vt[1] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h00210383,32'h104,32'h0,   32'h00800000,5'd7,3'd0,2'd2,1'b1,1'b1,5'd7,32'hFFFFFF80};
        vt[2] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h00214383,32'h108,32'h0,   32'h00800000,5'd7,3'd4,2'd2,1'b1,1'b1,5'd7,32'h00000080};
        vt[3] = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'h00628033,32'h10C,32'h55,  32'h0,       5'd0,3'd0,2'd0,1'b1,1'b0,5'd0,32'h00000055};
        vt[4] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'h006282B3,32'h110,32'h77,  32'h0,       5'd5,3'd0,2'd0,1'b0,1'b0,5'd0,32'h00000000};
        vt[5] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h00312503,32'h114,32'h0,   32'hCAFEBABE,5'd10,3'd2,2'd3,1'b1,1'b1,5'd10,32'hCAFEBABE};
        vt[6] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h00311583,32'h118,32'h0,   32'h80011234,5'd11,3'd1,2'd3,1'b1,1'b1,5'd11,32'hFFFF8001};
        vt[7] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'h00313603,32'h11C,32'h0,   32'hFFFFFFFF,5'd12,3'd3,2'd0,1'b1,1'b0,5'd12,32'h00000000};

        // Reset state
        rstn = 1'b1;
        step("rst0");
        step("rst1");
        expect_out("reset", 1'b0, 32'h13, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        rstn = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            stall_i = vt[i].stall; flush_i = vt[i].flush; valid_i = vt[i].valid;
            regs_wen_i = vt[i].wen; is_load_i = vt[i].is_load; dmem_rvalid_i = vt[i].rvalid;
            inst_i = vt[i].inst; instaddr_i = vt[i].addr; rd_data_i = vt[i].rdata_alu;
            dmem_rdata_i = vt[i].dmem; rd_addr_i = vt[i].rd; load_funct3_i = vt[i].f3;
            load_off_i = vt[i].off;
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.t_valid", i), 32'(valid_o), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d.t_wen", i), 32'(regs_wen_o), 32'(vt[i].e_wen));
            chk($sformatf("vec%0d.t_rd", i), 32'(rd_addr_o), 32'(vt[i].e_rd));
            chk($sformatf("vec%0d.t_data", i), rd_data_o, vt[i].e_data);
            if (vt[i].e_valid) chk($sformatf("vec%0d.t_inst", i), inst_o, vt[i].inst);
            else chk($sformatf("vec%0d.t_inst", i), inst_o, 32'h13);
        end

        // LHU with data arriving 3 cycles late
        idle_inputs();
        valid_i = 1'b1; is_load_i = 1'b1; regs_wen_i = 1'b1; rd_addr_i = 5'd9;
        load_funct3_i = 3'd5; load_off_i = 2'd2; inst_i = 32'h0021D483; instaddr_i = 32'h200;
        for (int c = 0; c < 3; c++) begin
            step($sformatf("lhu_wait%0d", c));
            expect_out($sformatf("lhu_wait%0d", c), 1'b0, 32'h13, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
            // Upstream junk on flush/stall/valid must be ignored while waiting.
            flush_i = (c == 0); stall_i = (c == 1);
        end
        flush_i = 1'b0; stall_i = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBEEF0000;
        step("lhu_done");
        expect_out("lhu_done", 1'b1, 32'h0021D483, 32'h200, 1'b1, 5'd9, 32'h0000BEEF, 1'b0);

        // Stall holds for two cycles
        idle_inputs();
        valid_i = 1'b1; regs_wen_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'hA5A5;
        inst_i = 32'h00A00193; instaddr_i = 32'h300;
        step("pre_stall");
        stall_i = 1'b1; rd_addr_i = 5'd4; rd_data_i = 32'h1111; instaddr_i = 32'h304;
        dmem_rvalid_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step($sformatf("stall%0d", c));
            expect_out($sformatf("stall%0d", c), 1'b1, 32'h00A00193, 32'h300, 1'b1, 5'd3, 32'hA5A5, 1'b0);
        end

        // Reset in WAIT, then stray rvalid
        idle_inputs();
        valid_i = 1'b1; is_load_i = 1'b1; regs_wen_i = 1'b1; rd_addr_i = 5'd6;
        load_funct3_i = 3'd2; inst_i = 32'h00012303; instaddr_i = 32'h400;
        step("wrst_load");
        idle_inputs();
        rstn = 1'b1;
        step("wrst_rst");
        expect_out("wrst_rst", 1'b0, 32'h13, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        rstn = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
        step("wrst_rv");
        expect_out("wrst_rv", 1'b0, 32'h13, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rstn          = ($urandom_range(0, 63) == 0);
            stall_i       = ($urandom_range(0, 4) == 0);
            flush_i       = ($urandom_range(0, 7) == 0);
            valid_i       = ($urandom_range(0, 5) != 0);
            is_load_i     = $urandom_range(0, 1) == 1;
            dmem_rvalid_i = $urandom_range(0, 2) == 0;
            regs_wen_i    = $urandom_range(0, 3) != 0;
            rd_addr_i     = 5'($urandom_range(0, 31));
            load_funct3_i = 3'($urandom_range(0, 7));
            load_off_i    = 2'($urandom_range(0, 3));
            inst_i        = $urandom;
            instaddr_i    = $urandom;
            rd_data_i     = $urandom;
            dmem_rdata_i  = $urandom;
            step($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
